// File: rtl/multicycle_controller.sv
// Multicycle RV32I-style control unit: a Moore FSM that sequences fetch, decode,
// execute and writeback, and counts retired instructions.
module multicycle_controller (
  input  logic        Clk,
  input  logic        Clear,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        funct7_5,
  input  logic        alu_zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        memwrite,
  output logic        adr_src,
  output logic        ir_write,
  output logic        pc_write,
  output logic        regwrite,
  output logic [1:0]  alu_srca,
  output logic [1:0]  alu_srcb,
  output logic [1:0]  result_src,
  output logic [3:0]  alu_control,
  output logic [3:0]  state,
  output logic        illegal,
  output logic [31:0] instret
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_LINK     = 4'd12,
    S_UPPER    = 4'd13,
    S_TRAP     = 4'd14
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;
  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  state_t      state_q, state_d;
  logic [31:0] instret_q, instret_d;
  state_t      decode_target;
  logic [3:0]  exec_alu;
  logic [3:0]  branch_alu;
  logic        branch_taken;

  logic        mem_req_c, memwrite_c, adr_src_c, ir_write_c, pc_write_c, regwrite_c;
  logic        illegal_c;
  logic [1:0]  alu_srca_c, alu_srcb_c, result_src_c;
  logic [3:0]  alu_control_c;

  // Encoding legality is resolved once in DECODE so later states never see a bad funct3.
  always_comb begin
    decode_target = S_TRAP;
    case (opcode)
      OP_LOAD:   if (funct3 != 3'b011 && funct3[2:1] != 2'b11) decode_target = S_MEMADR;
      OP_STORE:  if (funct3 <= 3'b010) decode_target = S_MEMADR;
      OP_RTYPE:  decode_target = S_EXECR;
      OP_ITYPE:  decode_target = S_EXECI;
      OP_BRANCH: if (funct3[2:1] != 2'b01) decode_target = S_BRANCH;
      OP_JAL:    decode_target = S_JAL;
      OP_JALR:   if (funct3 == 3'b000) decode_target = S_JALR;
      OP_LUI,
      OP_AUIPC:  decode_target = S_UPPER;
      default:   decode_target = S_TRAP;
    endcase
  end

  always_comb begin
    exec_alu = ALU_ADD;
    case (funct3)
      3'b000:  exec_alu = (state_q == S_EXECR && funct7_5) ? ALU_SUB : ALU_ADD;
      3'b001:  exec_alu = ALU_SLL;
      3'b010:  exec_alu = ALU_SLT;
      3'b011:  exec_alu = ALU_SLTU;
      3'b100:  exec_alu = ALU_XOR;
      3'b101:  exec_alu = funct7_5 ? ALU_SRA : ALU_SRL;
      3'b110:  exec_alu = ALU_OR;
      default: exec_alu = ALU_AND;
    endcase
  end

  // Even funct3 tests the compare for "equal/less", odd inverts it; 101/111 are >= forms.
  always_comb begin
    branch_alu   = ALU_ADD;
    branch_taken = 1'b0;
    case (funct3)
      3'b000:  begin branch_alu = ALU_SUB;  branch_taken = alu_zero;  end
      3'b001:  begin branch_alu = ALU_SUB;  branch_taken = ~alu_zero; end
      3'b100:  begin branch_alu = ALU_SLT;  branch_taken = ~alu_zero; end
      3'b101:  begin branch_alu = ALU_SLT;  branch_taken = alu_zero;  end
      3'b110:  begin branch_alu = ALU_SLTU; branch_taken = ~alu_zero; end
      3'b111:  begin branch_alu = ALU_SLTU; branch_taken = alu_zero;  end
      default: begin branch_alu = ALU_ADD;  branch_taken = 1'b0;      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE:   state_d = decode_target;
      S_MEMADR:   state_d = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JAL:      state_d = S_LINK;
      S_JALR:     state_d = S_LINK;
      S_LINK:     state_d = S_FETCH;
      S_UPPER:    state_d = S_ALUWB;
      S_TRAP:     state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // A return to FETCH retires an instruction unless it came from a trap or a fetch stall.
  always_comb begin
    instret_d = instret_q;
    if (state_d == S_FETCH && state_q != S_FETCH && state_q != S_TRAP)
      instret_d = instret_q + 32'd1;
  end

  always_ff @(posedge Clk or negedge Clear) begin
    if (!Clear) begin
      state_q   <= S_FETCH;
      instret_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    mem_req_c     = 1'b0;
    memwrite_c    = 1'b0;
    adr_src_c     = 1'b0;
    ir_write_c    = 1'b0;
    pc_write_c    = 1'b0;
    regwrite_c    = 1'b0;
    illegal_c     = 1'b0;
    alu_srca_c    = SRCA_PC;
    alu_srcb_c    = SRCB_RS2;
    result_src_c  = RES_ALUOUT;
    alu_control_c = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        mem_req_c = 1'b1;
        if (mem_ready) begin
          ir_write_c   = 1'b1;
          pc_write_c   = 1'b1;
          alu_srcb_c   = SRCB_FOUR;
          result_src_c = RES_ALU;
        end
      end
      S_DECODE: begin
        alu_srca_c = SRCA_OLDPC;
        alu_srcb_c = SRCB_IMM;
      end
      S_MEMADR: begin
        alu_srca_c = SRCA_RS1;
        alu_srcb_c = SRCB_IMM;
      end
      S_MEMREAD: begin
        mem_req_c = 1'b1;
        adr_src_c = 1'b1;
      end
      S_MEMWB: begin
        regwrite_c   = 1'b1;
        result_src_c = RES_MEM;
      end
      S_MEMWRITE: begin
        mem_req_c  = 1'b1;
        adr_src_c  = 1'b1;
        memwrite_c = 1'b1;
      end
      S_EXECR: begin
        alu_srca_c    = SRCA_RS1;
        alu_srcb_c    = SRCB_RS2;
        alu_control_c = exec_alu;
      end
      S_EXECI: begin
        alu_srca_c    = SRCA_RS1;
        alu_srcb_c    = SRCB_IMM;
        alu_control_c = exec_alu;
      end
      S_ALUWB: begin
        regwrite_c   = 1'b1;
        result_src_c = RES_ALUOUT;
      end
      S_BRANCH: begin
        alu_srca_c    = SRCA_RS1;
        alu_srcb_c    = SRCB_RS2;
        alu_control_c = branch_alu;
        pc_write_c    = branch_taken;
      end
      S_JAL: begin
        pc_write_c   = 1'b1;
        result_src_c = RES_ALUOUT;
      end
      S_JALR: begin
        alu_srca_c   = SRCA_RS1;
        alu_srcb_c   = SRCB_IMM;
        result_src_c = RES_ALU;
        pc_write_c   = 1'b1;
      end
      S_LINK: begin
        alu_srca_c   = SRCA_OLDPC;
        alu_srcb_c   = SRCB_FOUR;
        result_src_c = RES_ALU;
        regwrite_c   = 1'b1;
      end
      S_UPPER: begin
        alu_srca_c = (opcode == OP_LUI) ? SRCA_ZERO : SRCA_OLDPC;
        alu_srcb_c = SRCB_IMM;
      end
      S_TRAP: illegal_c = 1'b1;
      default: ;
    endcase
  end

  // Clear masks every control output combinationally so an in-flight access dies at once.
  assign mem_req     = Clear & mem_req_c;
  assign memwrite    = Clear & memwrite_c;
  assign adr_src     = Clear & adr_src_c;
  assign ir_write    = Clear & ir_write_c;
  assign pc_write    = Clear & pc_write_c;
  assign regwrite    = Clear & regwrite_c;
  assign illegal     = Clear & illegal_c;
  assign alu_srca    = Clear ? alu_srca_c    : 2'b00;
  assign alu_srcb    = Clear ? alu_srcb_c    : 2'b00;
  assign result_src  = Clear ? result_src_c  : 2'b00;
  assign alu_control = Clear ? alu_control_c : 4'd0;
  assign state       = state_q;
  assign instret     = instret_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller: each instruction is expanded into its
// expected state path and the DUT is compared cycle by cycle against it.
module tb_multicycle_controller;

  logic        Clk = 1'b0;
  logic        Clear;
  logic [6:0]  op;
  logic [2:0]  f3;
  logic        f75;
  logic        zero;
  logic        rdy;
  logic        mem_req, memwrite, adr_src, ir_write, pc_write, regwrite, illegal;
  logic [1:0]  alu_srca, alu_srcb, result_src;
  logic [3:0]  alu_control, state;
  logic [31:0] instret;
  logic [16:0] dut_outs;

  multicycle_controller dut (
    .Clk(Clk), .Clear(Clear), .opcode(op), .funct3(f3), .funct7_5(f75),
    .alu_zero(zero), .mem_ready(rdy), .mem_req(mem_req), .memwrite(memwrite),
    .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write), .regwrite(regwrite),
    .alu_srca(alu_srca), .alu_srcb(alu_srcb), .result_src(result_src),
    .alu_control(alu_control), .state(state), .illegal(illegal), .instret(instret)
  );

  always #5 Clk = ~Clk;

  assign dut_outs = {mem_req, memwrite, adr_src, ir_write, pc_write, regwrite,
                     alu_srca, alu_srcb, result_src, alu_control, illegal};

  int          n_checks = 0;
  int          n_errors = 0;
  int          path[$];
  int          idx;
  logic [31:0] exp_instret;
  bit          need_new;
  bit          force_store;
  bit          hold_low;
  logic [6:0]  op_tab [12] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                               7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                               7'b0010111, 7'b1111111, 7'b0110011, 7'b1100011};

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] exec_alu(input logic [2:0] fn, input logic f7, input bit is_r);
    case (fn)
      3'd0: return (is_r && f7) ? 4'd1 : 4'd0;
      3'd1: return 4'd7;
      3'd2: return 4'd5;
      3'd3: return 4'd6;
      3'd4: return 4'd4;
      3'd5: return f7 ? 4'd9 : 4'd8;
      3'd6: return 4'd3;
      default: return 4'd2;
    endcase
  endfunction

  // Expected outputs {mem_req,memwrite,adr_src,ir_write,pc_write,regwrite,srca,srcb,res,alu,illegal}
  function automatic logic [16:0] exp_outs(input int st, input logic [6:0] o, input logic [2:0] fn,
                                           input logic f7, input logic z, input logic r);
    logic mreq = 0, mwr = 0, adr = 0, irw = 0, pcw = 0, rw = 0, ill = 0;
    logic [1:0] sa = 0, sb = 0, rs = 0;
    logic [3:0] alu = 0;
    case (st)
      0: begin mreq = 1; if (r) begin irw = 1; pcw = 1; sb = 2; rs = 2; end end
      1: begin sa = 1; sb = 1; end
      2: begin sa = 2; sb = 1; end
      3: begin mreq = 1; adr = 1; end
      4: begin rw = 1; rs = 1; end
      5: begin mreq = 1; adr = 1; mwr = 1; end
      6: begin sa = 2; sb = 0; alu = exec_alu(fn, f7, 1'b1); end
      7: begin sa = 2; sb = 1; alu = exec_alu(fn, f7, 1'b0); end
      8: begin rw = 1; rs = 0; end
      9: begin
        sa = 2; sb = 0;
        alu = (fn <= 3'd1) ? 4'd1 : (fn <= 3'd5) ? 4'd5 : 4'd6;
        pcw = (fn == 3'd0 || fn == 3'd5 || fn == 3'd7) ? z : ~z;
      end
      10: pcw = 1;
      11: begin sa = 2; sb = 1; rs = 2; pcw = 1; end
      12: begin sa = 1; sb = 2; rs = 2; rw = 1; end
      13: begin sb = 1; sa = (o == 7'b0110111) ? 2'd3 : 2'd1; end
      14: ill = 1;
      default: ;
    endcase
    return {mreq, mwr, adr, irw, pcw, rw, sa, sb, rs, alu, ill};
  endfunction

  task automatic new_instruction();
    int r;
    if (force_store) begin
      op = 7'b0100011; f3 = 3'b010; force_store = 0;
    end else begin
      r = $urandom_range(0, 12);
      op = (r == 12) ? 7'($urandom) : op_tab[r];
      f3 = 3'($urandom);
    end
    f75 = 1'($urandom);
    path.delete();
    path.push_back(0);
    path.push_back(1);
    case (op)
      7'b0000011: if (f3 == 3 || f3 == 6 || f3 == 7) path.push_back(14);
                  else begin path.push_back(2); path.push_back(3); path.push_back(4); end
      7'b0100011: if (f3 > 2) path.push_back(14);
                  else begin path.push_back(2); path.push_back(5); end
      7'b0110011: begin path.push_back(6); path.push_back(8); end
      7'b0010011: begin path.push_back(7); path.push_back(8); end
      7'b1100011: path.push_back((f3 == 2 || f3 == 3) ? 14 : 9);
      7'b1101111: begin path.push_back(10); path.push_back(12); end
      7'b1100111: if (f3 != 0) path.push_back(14);
                  else begin path.push_back(11); path.push_back(12); end
      7'b0110111, 7'b0010111: begin path.push_back(13); path.push_back(8); end
      default: path.push_back(14);
    endcase
    idx = 0;
  endtask

  task automatic model_step();
    int st = path[idx];
    if ((st == 0 || st == 3 || st == 5) && !rdy) return;
    idx++;
    if (idx == path.size()) begin
      if (path[path.size()-1] != 14) exp_instret++;
      $display("instr op=%b f3=%b f7=%b states=%0d retired=%0d",
               op, f3, f75, path.size(), exp_instret);
      need_new = 1;
    end
  endtask

  task automatic drive_inputs();
    if (need_new) begin need_new = 0; new_instruction(); end
    rdy  = ($urandom_range(0, 9) < 6);
    if (hold_low && path[idx] == 5) rdy = 1'b0;
    zero = 1'($urandom);
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin
      @(negedge Clk);
      check_value("state", 32'(state), 32'(path[idx]));
      check_value("ctrl", 32'(dut_outs), 32'(exp_outs(path[idx], op, f3, f75, zero, rdy)));
      check_value("instret", instret, exp_instret);
      @(posedge Clk);
      model_step();
      #1;
      drive_inputs();
    end
  endtask

  initial begin
    int bound;
    Clear = 0; op = 7'b0000011; f3 = 0; f75 = 0; zero = 0; rdy = 1;
    need_new = 0; force_store = 0; hold_low = 0; exp_instret = 0;
    #12;
    check_value("rst_state", 32'(state), 32'd0);
    check_value("rst_ctrl", 32'(dut_outs), 32'd0);
    check_value("rst_instret", instret, 32'd0);
    @(posedge Clk); #2;
    check_value("rst_state_edge", 32'(state), 32'd0);
    check_value("rst_memreq_edge", 32'(mem_req), 32'd0);
    new_instruction();
    drive_inputs();
    Clear = 1;
    run_cycles(3000);

    // Abort a store that is stalled waiting for memory.
    force_store = 1;
    hold_low = 1;
    bound = 0;
    while (path[idx] != 5 && bound < 300) begin run_cycles(1); bound++; end
    if (path[idx] != 5) begin
      check_value("abort_reach", 32'd0, 32'd1);
    end else begin
      run_cycles(2);
      #3;
      check_value("abort_mw_before", 32'(memwrite), 32'd1);
      Clear = 0;
      #1;
      check_value("abort_memwrite", 32'(memwrite), 32'd0);
      check_value("abort_ctrl", 32'(dut_outs), 32'd0);
      check_value("abort_state", 32'(state), 32'd0);
      check_value("abort_instret", instret, 32'd0);
      @(posedge Clk); #2;
      check_value("abort_state_edge", 32'(state), 32'd0);
      check_value("abort_ctrl_edge", 32'(dut_outs), 32'd0);
    end
    hold_low = 0;
    exp_instret = 0;
    need_new = 1;
    drive_inputs();
    Clear = 1;
    run_cycles(1500);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have port Clk, input, 1, the single clock; all state changes on rising edge.
REQ-002 SHALL have port Clear, input, 1, reset, asynchronous and active-low (Clear=0 resets).
REQ-003 SHALL have inputs opcode[6:0], funct3[2:0] and funct7_5 (1), all from the instruction register.
REQ-004 SHALL have inputs alu_zero (1, ALU result==0) and mem_ready (1, memory handshake completion).
REQ-005 SHALL have outputs mem_req, memwrite, adr_src (0=PC, 1=aluout), ir_write, pc_write and regwrite, each 1 bit.
REQ-006 SHALL have output alu_srca[1:0]: 00=PC, 01=oldPC, 10=rs1, 11=zero.
REQ-007 SHALL have output alu_srcb[1:0]: 00=rs2, 01=imm, 10=const 4.
REQ-008 SHALL have output result_src[1:0]: 00=aluout register, 01=mem data, 10=ALU direct.
REQ-009 SHALL have output alu_control[3:0] encoded as ADD0 SUB1 AND2 OR3 XOR4 SLT5 SLTU6 SLL7 SRL8 SRA9.
REQ-010 SHALL have outputs state[3:0] (current state), illegal (1) and instret[31:0].

Function
REQ-011 SHALL implement a Moore FSM with states FETCH0 DECODE1 MEMADR2 MEMREAD3 MEMWB4 MEMWRITE5 EXECR6 EXECI7 ALUWB8 BRANCH9 JAL10 JALR11 LINK12 UPPER13 TRAP14; encoding 15 SHALL go to FETCH.
REQ-012 In FETCH, SHALL drive mem_req=1 and adr_src=0, and SHALL hold FETCH while mem_ready=0.
REQ-013 When FETCH sees mem_ready=1, SHALL pulse ir_write=1 and pc_write=1 with srca=00, srcb=10, ADD, result_src=10, then go to DECODE.
REQ-014 In DECODE, SHALL drive srca=01, srcb=01, ADD (target into aluout) and branch on opcode.
REQ-015 DECODE SHALL map 0000011/0100011 to MEMADR, 0110011 to EXECR, 0010011 to EXECI, 1100011 to BRANCH, 1101111 to JAL, 1100111 to JALR, 0110111/0010111 to UPPER, and any other opcode to TRAP.
REQ-016 MEMADR SHALL drive srca=10, srcb=01, ADD, then go to MEMREAD for loads or MEMWRITE for stores.
REQ-017 MEMREAD and MEMWRITE SHALL hold mem_req=1 and adr_src=1 (memwrite=1 in MEMWRITE) stable until mem_ready=1.
REQ-018 On mem_ready=1, MEMREAD SHALL go to MEMWB and MEMWRITE SHALL go to FETCH.
REQ-019 MEMWB SHALL drive regwrite=1 with result_src=01, then go to FETCH.
REQ-020 EXECR SHALL use srca=10, srcb=00; EXECI SHALL use srca=10, srcb=01; both SHALL then go to ALUWB.
REQ-021 EXECR/EXECI alu_control SHALL decode funct3 as 000 ADD (SUB only if R-type and funct7_5=1), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA (SRA when funct7_5=1), 110 OR, 111 AND.
REQ-022 ALUWB SHALL drive regwrite=1 with result_src=00, then go to FETCH.
REQ-023 BRANCH SHALL drive srca=10, srcb=00, result_src=00, with SUB for funct3 000/001, SLT for 100/101 and SLTU for 110/111.
REQ-024 BRANCH SHALL set pc_write = alu_zero for funct3 000/101/111 and ~alu_zero for 001/100/110, then go to FETCH.
REQ-025 JAL SHALL drive pc_write=1 with result_src=00, then go to LINK.
REQ-026 JALR SHALL drive srca=10, srcb=01, ADD, result_src=10 and pc_write=1, then go to LINK.
REQ-027 LINK SHALL drive srca=01, srcb=10, ADD, result_src=10 and regwrite=1, then go to FETCH.
REQ-028 UPPER SHALL drive srcb=01, ADD, with srca=11 for opcode 0110111 and srca=01 for 0010111, then go to ALUWB.
REQ-029 Illegal encodings SHALL go to TRAP: branch funct3 010/011, load funct3 011/110/111, store funct3 >010, and JALR funct3 !=000.
REQ-030 TRAP SHALL pulse illegal=1 for one cycle with no writes, then go to FETCH.
REQ-031 instret SHALL increment by 1 on each transition into FETCH from any state except FETCH and TRAP, wrapping FFFFFFFF->0.
REQ-032 All output values not listed for a state SHALL be 0.

Reset
REQ-033 While Clear=0, state SHALL be FETCH, instret=0, and all control outputs including mem_req SHALL be forced to 0, independent of Clk.
REQ-034 Clear asserted mid-access SHALL abort the access, with no write pulse on release.
REQ-035 After Clear rises, the first Clk edge SHALL begin FETCH.

Verification
REQ-036 ADD, opcode 0110011, funct3 000, funct7_5 0, mem_ready=1 -> states 0,1,6,8,0; alu_control 0 in EXECR; regwrite in ALUWB; instret=1.
REQ-037 LW with mem_ready held low 3 cycles in MEMREAD -> mem_req/adr_src=1 held stable; MEMWB regwrite result_src=01; 6 states total plus waits.
REQ-038 BNE, funct3 001, alu_zero=1 -> pc_write=0 in BRANCH; alu_zero=0 -> pc_write=1.
REQ-039 JALR, funct3 000 -> JALR pc_write with result_src=10, then LINK regwrite with srca=01, srcb=10.
REQ-040 opcode 1111111 -> TRAP, illegal high exactly 1 cycle, instret unchanged.
REQ-041 Clear low during MEMWRITE wait -> memwrite=0 immediately; state=0; instret=0.
